// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data has priority, bounded by a streak limit; a timeout aborts silent memories.
module mem_arbiter #(
   parameter int unsigned AW         = 8,
   parameter int unsigned DW         = 8,
   parameter int unsigned FAIR_LIMIT = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          owner,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int unsigned SW = $clog2(FAIR_LIMIT + 1);
   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_LIMIT);
   localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [SW-1:0] streak, streak_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          mem_en_nxt, mem_we_nxt, err_nxt, if_done_nxt, d_done_nxt;
   logic          owner_nxt, busy_nxt, grant_data;
   logic [AW-1:0] mem_addr_nxt;
   logic [DW-1:0] mem_wdata_nxt, rdata_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         streak    <= '0;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         err       <= 1'b0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         owner     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         streak    <= streak_nxt;
         cnt       <= cnt_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         rdata     <= rdata_nxt;
         err       <= err_nxt;
         if_done   <= if_done_nxt;
         d_done    <= d_done_nxt;
         owner     <= owner_nxt;
         busy      <= busy_nxt;
      end
   end

   // Fetch only overrides data once the data streak has hit the fairness limit
   assign grant_data = d_req && !(if_req && (streak == STREAK_MAX));

   always_comb begin
      state_nxt     = state;
      streak_nxt    = streak;
      cnt_nxt       = cnt;
      mem_en_nxt    = mem_en;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      rdata_nxt     = rdata;
      err_nxt       = err;
      if_done_nxt   = 1'b0;
      d_done_nxt    = 1'b0;
      owner_nxt     = owner;
      busy_nxt      = busy;
      unique case (state)
         IDLE: begin
            if (if_req || d_req) begin
               state_nxt  = BUSY;
               cnt_nxt    = '0;
               mem_en_nxt = 1'b1;
               busy_nxt   = 1'b1;
               owner_nxt  = grant_data;
               if (grant_data) begin
                  mem_we_nxt    = d_we;
                  mem_addr_nxt  = d_addr;
                  mem_wdata_nxt = d_wdata;
                  if (!if_req)
                     streak_nxt = '0;
                  else if (streak != STREAK_MAX)
                     streak_nxt = streak + 1'b1;
               end else begin
                  mem_we_nxt   = 1'b0;
                  mem_addr_nxt = if_addr;
                  streak_nxt   = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ready || (cnt == CNT_LAST)) begin
               state_nxt   = RESP;
               mem_en_nxt  = 1'b0;
               mem_we_nxt  = 1'b0;
               err_nxt     = !mem_ready;
               rdata_nxt   = (mem_ready && !mem_we) ? mem_rdata : '0;
               if_done_nxt = !owner;
               d_done_nxt  = owner;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single-port memory between the instruction-fetch path and the data load/store path. Operates under control-unit sequencing. Each requester holds a request until a one-cycle done pulse. The arbiter owns the memory bus for exactly one transaction at a time. Data accesses have priority, with a streak limit that prevents fetch starvation. A timeout aborts transactions whose memory never answers.

## Interface
- AW, 8, address width
- DW, 8, data width
- FAIR_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 16, max cycles mem_en stays high per transaction (≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address, stable while if_req high
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_done  out  1  one-cycle data completion pulse
- rdata  out  DW  read data, valid in the done cycle
- err  out  1  high with done when the transaction timed out
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_en high
- owner  out  1  current/last grant: 0 = fetch, 1 = data
- busy  out  1  high in BUSY and RESP

## Operation
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, any request: grant and latch addr/we/wdata into the mem_* registers. Next state is BUSY with mem_en=1 and the timeout counter at 0.
- Grant rule for both requests: fetch wins iff streak == FAIR_LIMIT; otherwise data wins.
- Grant rule for a single request: that requester wins.
- Fetch grant forces mem_we=0.
- streak (0..FAIR_LIMIT) updates at data grant: +1 saturating if if_req=1, else cleared to 0. It clears to 0 on any fetch grant.
- BUSY, mem_ready=1: capture rdata (mem_rdata on reads, 0 on writes) and set err=0. Drop mem_en/mem_we. Go to RESP.
- BUSY, mem_ready=0 with counter == TIMEOUT−1: abort with rdata=0 and err=1. Drop mem_en/mem_we. Go to RESP.
- BUSY, otherwise: increment the counter and keep mem_* stable.
- mem_ready wins over timeout in the same cycle.
- RESP: assert the owner's done for exactly this cycle; the other done stays 0. No arbitration in RESP. Next state is IDLE; done, err and busy drop.
- Requesters must deassert req, or present a new transaction, by the edge ending their done cycle. Req still high in the following IDLE cycle is a new request.
- Changing addr/data/we while req is high and ungranted is legal. Only values at grant are used.
- Dropping req after grant does not cancel the transaction; done still pulses.
- mem_addr/mem_wdata hold their last values outside BUSY.

## Timing
- Reset (async, immediate) values:
  - Outputs: all 0 — mem_en, mem_we, mem_addr, mem_wdata, rdata, err, if_done, d_done, owner, busy.
  - Internal: state=IDLE, streak=0, counter=0.
- Reset mid-transaction: the transaction is lost. No done pulse follows deassertion.
- Latency, req seen high at edge E0:
  - mem_en high from E0+.
  - mem_ready high in the k-th BUSY cycle gives a done pulse in the cycle after it: k+1 cycles after E0.
  - Minimum is 2 cycles; back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout: mem_en high exactly TIMEOUT cycles, then done+err in the next cycle.
- busy is high from the BUSY entry edge through the RESP cycle.
- owner updates at the grant edge.

## Test plan
- Single fetch: if_req=1, if_addr=0x3C, mem_ready=1 in the first BUSY cycle, mem_rdata=0xA5 → mem_en 1 cycle with mem_addr=0x3C, mem_we=0. if_done with rdata=0xA5, err=0 at 2 cycles after the request.
- Data write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0x7E, mem_ready after 3 cycles → mem_we=1, mem_wdata=0x7E for 3 cycles. d_done with rdata=0x00; if_done stays 0.
- Starvation limit: if_req and d_req held continuously (re-asserted after each done), memory always ready → grant order is D,D,D,D,F,D,D,D,D,F; streak clears after each F.
- Timeout: d_req read, mem_ready held 0 → mem_en high exactly 16 cycles, then d_done=1, err=1, rdata=0x00. Then back to IDLE.
- Ready vs timeout: mem_ready rises in the 16th BUSY cycle with mem_rdata=0x42 → err=0, rdata=0x42.
- Async reset: assert rst_n=0 in the 2nd BUSY cycle → all outputs 0 immediately. After release with no req: no done pulse, state IDLE, and the next request is granted normally.
